shadow_dump_ctrl: RTL
=====================

# shadow_dump_ctrl

Dump sequencer and word packer that sits directly downstream of `shadow_capture`. On a start request it enables one output chain at a time through `dump_en` and collects that chain's serial bits from `chains_out`/`chains_out_vld`. It packs the bits LSB-first into `WORD_W`-bit words and presents them on a single-entry valid/ready port to the host/debug link. Chains are visited in ascending index order and skipped if masked.

## Interface
Parameters:
- `NUM_CHAINS`, 32, number of shadow chains (matches `CHAINS_OUT` of `shadow_capture`)
- `WORD_W`, 32, packed output word width
- `IDX_W`, 5, chain index width, equal to `$clog2(NUM_CHAINS)`
- `CNT_W`, 16, per-chain bit counter width

Ports:
- `sh_clk`  in  1  shadow/data clock
- `sh_rst_n`  in  1  asynchronous reset, active-low
- `start`  in  1  one-cycle pulse that begins a dump pass; ignored while `busy`
- `chain_mask`  in  NUM_CHAINS  1 = dump this chain; sampled on the `start` cycle
- `dump_en`  out  NUM_CHAINS  one-hot chain advance enable
- `chains_out`  in  NUM_CHAINS  serial data from the chains
- `chains_out_vld`  in  NUM_CHAINS  per-chain bit valid
- `chains_out_done`  in  NUM_CHAINS  per-chain end-of-chain flag
- `word_data`  out  WORD_W  packed word
- `word_chain`  out  IDX_W  source chain of `word_data`
- `word_last`  out  1  marks the final word of the current chain
- `word_vld`  out  1  output word valid
- `word_rdy`  in  1  consumer ready
- `busy`  out  1  high from the cycle after `start` until the pass ends
- `pass_done`  out  1  one-cycle pulse when the pass completes

## Operation
- States: `IDLE`, `SEEK`, `DUMP`, `FLUSH`, `TRAIL`, `FIN`.
- `IDLE`: on `start`, latch `chain_mask`, set `cur`=0 and go to `SEEK`.
- `SEEK`: if `cur`==NUM_CHAINS, go to `FIN`. Otherwise, if `mask[cur]`==1, clear the pack register and the bit counter and go to `DUMP`. Otherwise increment `cur` and stay in `SEEK`. Each `SEEK` evaluation takes 1 cycle.
- `DUMP`:
  - `dump_en[cur]` is high only while the pack register is not full. All other `dump_en` bits are always 0.
  - A bit is accepted when `dump_en[cur]` && `chains_out_vld[cur]`. It is written at position `cnt mod WORD_W`, and `cnt` increments, saturating at 2^CNT_W−1.
  - When the pack register fills, it transfers to the output register as soon as the output register is empty or is accepted in the same cycle.
  - `chains_out_done[cur]` moves the FSM to `FLUSH`. A bit accepted in the same cycle as done is included.
- `FLUSH`: the partial pack register is zero-padded and transferred to the output.
  - Without the trailer, the flush word is always emitted, including an all-zero word when `cnt mod WORD_W`==0, and carries `word_last`=1.
  - With the trailer, the flush word is emitted only if the partial is non-empty.
  - Next state is `TRAIL` (trailer enabled) or `SEEK` with `cur`+1.
- `FIN`: pulse `pass_done`, then return to `IDLE`.
- Output handshake: a word transfers when `word_vld` && `word_rdy`. While `word_vld` is high and unaccepted, `word_data`, `word_chain` and `word_last` are held stable.
- Mask all zero: `SEEK` walks every index, then `FIN`. No words are emitted.
- Reset mid-pass returns the block to `IDLE` immediately. It drops `dump_en`, and any partial word is discarded.

## Timing
- Reset values: `dump_en`=0, `word_vld`=0, `word_data`=0, `word_chain`=0, `word_last`=0, `busy`=0, `pass_done`=0.
- `busy` rises 1 cycle after `start` and falls in the same cycle `pass_done` pulses.
- `dump_en[cur]` rises 1 cycle after entering `DUMP`.
- Latency from the accepting edge of the WORD_W-th bit to `word_vld`: 1 cycle when the output register is free.
- Throughput: 1 bit per cycle sustained while `word_rdy` is held high.
- All outputs are registered.

## Configuration
- `SHADOW_DUMP_TRAILER_EN` defined: after each chain, emit a trailer word `{zero pad, cur[IDX_W-1:0], cnt[CNT_W-1:0]}`, with `cnt` in bits [CNT_W-1:0] and `cur` above it. The trailer carries `word_last`=1 and the data words carry 0.
- Undefined: no `TRAIL` state and no trailer word. The flush word is the last word and carries `word_last`=1.

## Structure
- Shared package `shadow_dump_pkg`: the FSM state enum, the trailer field offsets, and the default widths.
- One sub-module, `shadow_word_packer`: shift-in, count, full/flush and zero-pad logic, driven by `shadow_dump_ctrl`.

## Test plan
- Mask 0x1, chain 0 supplies 40 bits `0xA5A5A5A5_FF` then done, `word_rdy`=1. Required: word0 = 0xA5A5A5A5 with `word_last`=0, word1 = 0x000000FF with `word_last`=1 (trailer off), then `pass_done`.
- Mask 0x0000_0005, each chain supplies 32 bits. Required: only chains 0 and 2 get `dump_en`, and `word_chain` reads 0 then 2.
- `word_rdy` held low for 50 cycles mid-chain. Required: `dump_en` drops once the pack register is full, `word_data` stays stable, and no bit is lost.
- Chain done with 0 bits, trailer on. Required: a single trailer word with `cnt`=0, `cur`=chain index and `word_last`=1.
- `sh_rst_n` asserted during `DUMP`. Required: `dump_en`, `word_vld` and `busy` are 0 in the same cycle, and a new `start` after release completes normally.
- `start` pulsed while `busy`. Required: it is ignored and the pass completes exactly once.

Source files
------------

// File: rtl/shadow_dump_pkg.sv
// Shared state enum, default widths and trailer layout for the dump path.
// SHADOW_DUMP_TRAILER_EN adds the TRAIL state and per-chain trailer words.
package shadow_dump_pkg;

    localparam int DEF_NUM_CHAINS = 32;
    localparam int DEF_WORD_W     = 32;
    localparam int DEF_IDX_W      = 5;
    localparam int DEF_CNT_W      = 16;

    // Trailer: cnt at TRL_CNT_LSB, chain index directly above it.
    localparam int TRL_CNT_LSB = 0;

`ifdef SHADOW_DUMP_TRAILER_EN
    localparam bit TRAILER_EN = 1'b1;
`else
    localparam bit TRAILER_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        SEEK,
        DUMP,
        FLUSH,
`ifdef SHADOW_DUMP_TRAILER_EN
        TRAIL,
`endif
        FIN
    } dump_state_e;

endpackage

// File: rtl/shadow_word_packer.sv
// LSB-first bit packer with fill tracking and a saturating chain bit count.
module shadow_word_packer
    import shadow_dump_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              take,
    input  logic              shift,
    input  logic              din,
    output logic [WORD_W-1:0] merged,
    output logic              full,
    output logic              nonempty,
    output logic [CNT_W-1:0]  cnt
);

    localparam int FW = $clog2(WORD_W) + 1;

    logic [WORD_W-1:0] pack;
    logic [FW-1:0]     fill;
    logic [FW-1:0]     fill_m;

    // Bits above fill are always zero, so the flush word is already padded.
    always_comb begin
        merged = pack;
        fill_m = fill;
        if (shift) begin
            merged[fill[FW-2:0]] = din;
            fill_m = fill + FW'(1);
        end
    end

    assign full     = (fill_m == FW'(WORD_W));
    assign nonempty = (fill_m != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack <= '0;
            fill <= '0;
            cnt  <= '0;
        end else begin
            if (clr || take) begin
                pack <= '0;
                fill <= '0;
            end else begin
                pack <= merged;
                fill <= fill_m;
            end
            if (clr)
                cnt <= '0;
            else if (shift && cnt != '1)
                cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/shadow_dump_ctrl.sv
// Walks masked shadow chains, packs their bits and emits words on valid/ready.
// SHADOW_DUMP_TRAILER_EN appends a {cur, cnt} trailer word after each chain.
module shadow_dump_ctrl
    import shadow_dump_pkg::*;
#(
    parameter int NUM_CHAINS = DEF_NUM_CHAINS,
    parameter int WORD_W     = DEF_WORD_W,
    parameter int IDX_W      = DEF_IDX_W,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                  sh_clk,
    input  logic                  sh_rst_n,
    input  logic                  start,
    input  logic [NUM_CHAINS-1:0] chain_mask,
    output logic [NUM_CHAINS-1:0] dump_en,
    input  logic [NUM_CHAINS-1:0] chains_out,
    input  logic [NUM_CHAINS-1:0] chains_out_vld,
    input  logic [NUM_CHAINS-1:0] chains_out_done,
    output logic [WORD_W-1:0]     word_data,
    output logic [IDX_W-1:0]      word_chain,
    output logic                  word_last,
    output logic                  word_vld,
    input  logic                  word_rdy,
    output logic                  busy,
    output logic                  pass_done
);

    dump_state_e state, nxt;

    logic [NUM_CHAINS-1:0] mask;
    logic [IDX_W:0]        cur;
    logic [IDX_W-1:0]      cur_i;
    logic                  cur_end;
    logic                  out_free;
    logic                  accept;
    logic                  clr, take, load, ld_last, ld_trl;
    logic                  cur_inc, en_d, leave;
    logic [WORD_W-1:0]     merged, trl, ld_data;
    logic                  full, nonempty;
    logic [CNT_W-1:0]      cnt;

    assign cur_i    = cur[IDX_W-1:0];
    assign cur_end  = (cur == (IDX_W+1)'(NUM_CHAINS));
    assign out_free = !word_vld || word_rdy;
    assign accept   = (state == DUMP) && dump_en[cur_i]
                      && chains_out_vld[cur_i];

    shadow_word_packer #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_packer (
        .clk      (sh_clk),
        .rst_n    (sh_rst_n),
        .clr      (clr),
        .take     (take),
        .shift    (accept),
        .din      (chains_out[cur_i]),
        .merged   (merged),
        .full     (full),
        .nonempty (nonempty),
        .cnt      (cnt)
    );

    always_comb begin
        trl = '0;
        trl[TRL_CNT_LSB +: CNT_W] = cnt;
        trl[TRL_CNT_LSB + CNT_W +: IDX_W] = cur_i;
    end

    assign ld_data = ld_trl ? trl : merged;

    always_ff @(posedge sh_clk or negedge sh_rst_n) begin
        if (!sh_rst_n)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt     = state;
        clr     = 1'b0;
        take    = 1'b0;
        load    = 1'b0;
        ld_last = 1'b0;
        ld_trl  = 1'b0;
        cur_inc = 1'b0;
        en_d    = 1'b0;
        leave   = 1'b0;
        unique case (state)
            IDLE: if (start) nxt = SEEK;
            SEEK: begin
                if (cur_end) begin
                    nxt = FIN;
                end else if (mask[cur_i]) begin
                    clr = 1'b1;
                    nxt = DUMP;
                end else begin
                    cur_inc = 1'b1;
                end
            end
            DUMP: begin
                if (full && out_free) begin
                    load = 1'b1;
                    take = 1'b1;
                end
                if (chains_out_done[cur_i]) nxt = FLUSH;
                en_d = (nxt == DUMP) && !(full && !take);
            end
            // A full word left over from backpressure goes out first.
            FLUSH: begin
                if (full || nonempty || !TRAILER_EN) begin
                    if (out_free) begin
                        load    = 1'b1;
                        take    = 1'b1;
                        ld_last = !full && !TRAILER_EN;
                        leave   = !full;
                    end
                end else begin
                    leave = 1'b1;
                end
            end
`ifdef SHADOW_DUMP_TRAILER_EN
            TRAIL: begin
                if (out_free) begin
                    load    = 1'b1;
                    ld_trl  = 1'b1;
                    ld_last = 1'b1;
                    cur_inc = 1'b1;
                    nxt     = SEEK;
                end
            end
`endif
            FIN: nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (leave) begin
`ifdef SHADOW_DUMP_TRAILER_EN
            nxt = TRAIL;
`else
            nxt     = SEEK;
            cur_inc = 1'b1;
`endif
        end
    end

    always_ff @(posedge sh_clk or negedge sh_rst_n) begin
        if (!sh_rst_n) begin
            mask       <= '0;
            cur        <= '0;
            dump_en    <= '0;
            word_vld   <= 1'b0;
            word_data  <= '0;
            word_chain <= '0;
            word_last  <= 1'b0;
            busy       <= 1'b0;
            pass_done  <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                mask <= chain_mask;
                cur  <= '0;
            end else if (cur_inc) begin
                cur <= cur + (IDX_W+1)'(1);
            end
            dump_en <= en_d ? (NUM_CHAINS'(1) << cur_i) : '0;
            if (load) begin
                word_vld   <= 1'b1;
                word_data  <= ld_data;
                word_chain <= cur_i;
                word_last  <= ld_last;
            end else if (word_rdy) begin
                word_vld <= 1'b0;
            end
            busy      <= (nxt != IDLE) && (nxt != FIN);
            pass_done <= (nxt == FIN);
        end
    end

endmodule
